gcd_operand_feeder: RTL and testbench
=====================================

Name: gcd_operand_feeder

Overview:
- Sequencer directly upstream of the GCD engine (datapath + controller pair).
- Accepts operand pairs on a valid/ready interface and buffers them in a small FIFO.
- Serialises each pair onto the engine's shared 16-bit data_in bus (A first, then B), pulses start, waits for done, and returns the captured GCD result on a valid/ready output.
- Zero operands are short-circuited so the subtractive engine is never started on them.

Parameters:
- WIDTH, 16, operand/result width; matches engine data_in.
- DEPTH, 4, operand-pair FIFO entries; power of 2, at least 2.
- TMO_CYCLES, 1024, watchdog limit in cycles; used only with GCD_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- gcd_start  out  1  start to engine controller.
- gcd_data  out  WIDTH  drives engine data_in.
- gcd_done  in  1  engine done.
- gcd_result  in  WIDTH  engine A register (aout).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  GCD result.
- out_zero  out  1  result produced by zero short-circuit, not by the engine.
- out_err  out  1  watchdog expiry; always 0 without GCD_TIMEOUT_EN.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset: FIFO empty, FSM in IDLE, and the following outputs are 0: in_ready, gcd_start, gcd_data, out_valid, out_data, out_zero, out_err.
- in_ready is 1 from the first cycle after reset while the FIFO is not full.
- FIFO write: on in_valid && in_ready, {in_a, in_b} is written.
- FIFO read: pops in IDLE when not empty.
- Simultaneous push and pop when full: the push is refused, because in_ready is registered from the full flag.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE, FIFO empty: stay in IDLE.
- IDLE, FIFO not empty: pop the pair into registers ra/rb.
  - If ra==0 or rb==0: out_data = ra|rb (gcd(0,x)=x, gcd(0,0)=0), out_zero=1, go to RESP.
  - Otherwise go to LOAD_A.
- LOAD_A (1 cycle): gcd_start=1, gcd_data=ra, then go to LOAD_B.
- LOAD_B (1 cycle): gcd_start=1, gcd_data=rb, then go to WAIT.
- WAIT: gcd_start=0 and gcd_data holds rb. On gcd_done=1, capture gcd_result into out_data, set out_zero=0, go to RESP.
- gcd_done sampled in LOAD_A or LOAD_B is ignored as stale from the previous run.
- RESP: out_valid=1 and out_data/out_zero/out_err are held stable until out_ready=1; then out_valid falls next cycle and the FSM returns to IDLE.
- Latency, non-zero pair: pop to gcd_start rise is 1 cycle; gcd_done to out_valid is 1 cycle.
- Zero pair: pop to out_valid is 1 cycle.
- Only one pair is in flight at a time; the FIFO continues accepting input during WAIT and RESP.
- rst mid-operation: FIFO is flushed, the in-flight pair is discarded, gcd_start drops the same edge, and out_valid is cleared.

Optional Feature:
- Macro: GCD_TIMEOUT_EN.
- With it:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - At TMO_CYCLES without gcd_done, the FSM goes to RESP with out_data=0, out_err=1, out_zero=0.
  - The next pair then drives LOAD_A normally; the engine restart relies on start.
- Without it: no counter is built, WAIT waits indefinitely, and out_err is tied to 0.

Test Plan:
- Push (143,78); engine model returns 13 -> gcd_data=143 then 78 on consecutive cycles with gcd_start high in both; out_data=13, out_zero=0, one cycle after gcd_done.
- Push (0,25), then (0,0) -> no gcd_start pulse; out_data=25 then 0, out_zero=1 for each.
- Push 5 pairs back-to-back with DEPTH=4 and the engine stalled -> in_ready low after the 4th accept; order preserved on output; 5th pair accepted once the first pop occurs.
- Hold out_ready=0 for 10 cycles in RESP with result 7 -> out_valid and out_data=7 stable throughout; no new gcd_start until the handshake completes.
- Assert rst during WAIT with 2 pairs queued -> next cycle in_ready=1 and out_valid=0; no stale result emitted after a later gcd_done.
- GCD_TIMEOUT_EN, TMO_CYCLES=16, gcd_done never asserted -> out_valid with out_err=1 and out_data=0 after 16 WAIT cycles; following pair (48,18) yields 6.

Source files
------------

// File: rtl/gcd_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// gcd_operand_feeder_if
// Operand-in, engine and result-out signal bundle for gcd_operand_feeder.
// Revision: 1.0
// ============================================================================
interface gcd_operand_feeder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_err;

  // master: producer, GCD engine and consumer around the feeder
  modport master (
    output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    input  in_ready, gcd_start, gcd_data, out_valid, out_data, out_zero, out_err
  );

  // slave: the feeder itself
  modport slave (
    input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
    output in_ready, gcd_start, gcd_data, out_valid, out_data, out_zero, out_err
  );
endinterface
`default_nettype wire

// File: rtl/gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// gcd_operand_feeder
// Buffers operand pairs, serialises them onto the GCD engine bus and returns
// the result. Optional macro GCD_TIMEOUT_EN adds a WAIT-state watchdog.
// Revision: 1.0
// ============================================================================
module gcd_operand_feeder #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int TMO_CYCLES = 1024
) (
  input  wire logic           clk,
  input  wire logic           rst,
  gcd_operand_feeder_if.slave bus
);

  localparam int                 c_ptr_w    = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full_cnt = (c_ptr_w + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYCLES < 1) begin : g_bad_params
    $error("gcd_operand_feeder: DEPTH must be a power of 2 >= 2 and TMO_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [c_ptr_w:0]   wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w:0]   rd_ptr_q, rd_ptr_d;
  logic               in_ready_q, in_ready_d;
  logic               w_push, w_pop, w_empty;
  logic [WIDTH-1:0]   w_head_a, w_head_b;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic               gcd_start_q, gcd_start_d;
  logic [WIDTH-1:0]   gcd_data_q, gcd_data_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_zero_q, out_zero_d;

`ifdef GCD_TIMEOUT_EN
  localparam int                 c_tmo_w    = $clog2(TMO_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO_CYCLES - 1);
  logic [c_tmo_w-1:0] tmo_cnt_q, tmo_cnt_d;
  logic               out_err_q, out_err_d;
`endif

  assign w_push                 = bus.in_valid && in_ready_q;
  assign w_empty                = (wr_ptr_q == rd_ptr_q);
  assign {w_head_a, w_head_b}   = mem_q[rd_ptr_q[c_ptr_w-1:0]];

  // in_ready looks at next-cycle occupancy so a full FIFO never takes a push
  always_comb begin
    wr_ptr_d   = wr_ptr_q + (c_ptr_w + 1)'(w_push);
    rd_ptr_d   = rd_ptr_q + (c_ptr_w + 1)'(w_pop);
    in_ready_d = ((wr_ptr_d - rd_ptr_d) != c_full_cnt);
  end

  always_comb begin
    state_d     = state_q;
    rb_d        = rb_q;
    gcd_start_d = 1'b0;
    gcd_data_d  = gcd_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    w_pop       = 1'b0;
`ifdef GCD_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          rb_d  = w_head_b;
          // gcd(0,x)=x and gcd(0,0)=0 both reduce to a|b
          if (w_head_a == '0 || w_head_b == '0) begin
            out_valid_d = 1'b1;
            out_data_d  = w_head_a | w_head_b;
            out_zero_d  = 1'b1;
`ifdef GCD_TIMEOUT_EN
            out_err_d   = 1'b0;
`endif
            state_d     = S_RESP;
          end else begin
            gcd_start_d = 1'b1;
            gcd_data_d  = w_head_a;
            state_d     = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        gcd_start_d = 1'b1;
        gcd_data_d  = rb_q;
        state_d     = S_LOAD_B;
      end
      S_LOAD_B: begin
`ifdef GCD_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.gcd_done) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.gcd_result;
          out_zero_d  = 1'b0;
`ifdef GCD_TIMEOUT_EN
          out_err_d   = 1'b0;
`endif
          state_d     = S_RESP;
        end
`ifdef GCD_TIMEOUT_EN
        else if (tmo_cnt_q == c_tmo_last) begin
          out_valid_d = 1'b1;
          out_data_d  = '0;
          out_zero_d  = 1'b0;
          out_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + c_tmo_w'(1);
        end
`endif
      end
      S_RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[c_ptr_w-1:0]] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_ready_q  <= 1'b0;
      state_q     <= S_IDLE;
      rb_q        <= '0;
      gcd_start_q <= 1'b0;
      gcd_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
`ifdef GCD_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      state_q     <= state_d;
      rb_q        <= rb_d;
      gcd_start_q <= gcd_start_d;
      gcd_data_q  <= gcd_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
`ifdef GCD_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.gcd_start = gcd_start_q;
  assign bus.gcd_data  = gcd_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
`ifdef GCD_TIMEOUT_EN
  assign bus.out_err   = out_err_q;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// tb_gcd_operand_feeder
// Directed bench with a behavioural engine, result scoreboard and out checker.
// Revision: 1.0
// ============================================================================
module tb_gcd_operand_feeder;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed { logic [15:0] a; logic [15:0] b; } pair_t;
  typedef struct packed { logic [15:0] data; logic zero; logic err; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_operand_feeder_if #(.WIDTH(WIDTH)) bus ();

  gcd_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_vec = 0;
  int    n_bad = 0;
  res_t  exp_q[$];
  pair_t eng_q[$];
  bit    eng_stall = 1'b0;
  bit    eng_hang  = 1'b0;
  int    eng_delay = 3;
  int    rst_epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] gcd_f(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one pair, wait (bounded) for acceptance, then record what must come out.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input bit hang);
    int    t;
    res_t  r;
    pair_t p;
    t = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin @(negedge clk); t++; end
    if (!bus.in_ready) check("push_accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (a == 0 || b == 0) begin
      r = '{data: a | b, zero: 1'b1, err: 1'b0};
    end else begin
      p = '{a: a, b: b};
      eng_q.push_back(p);
      if (hang) r = '{data: 16'd0, zero: 1'b0, err: 1'b1};
      else      r = '{data: gcd_f(a, b), zero: 1'b0, err: 1'b0};
    end
    exp_q.push_back(r);
  endtask

  task automatic wait_out(output logic [15:0] d, output logic z, output logic e);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.out_valid && t < 500);
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
    d = bus.out_data; z = bus.out_zero; e = bus.out_err;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin tick(); t++; end
    check("drain", exp_q.size(), 0);
  endtask

  // Engine model: captures A then B, answers with gcd(A,B) after a delay.
  initial begin : engine
    logic [15:0] ea, eb;
    bit          hang_now;
    int          ep, t;
    pair_t       p;
    bus.gcd_done = 1'b0; bus.gcd_result = '0;
    forever begin
      @(negedge clk);
      if (bus.gcd_start && !rst) begin
        ea = bus.gcd_data; hang_now = eng_hang; ep = rst_epoch;
        @(negedge clk);
        check("start_2nd_cycle", bus.gcd_start, 1);
        eb = bus.gcd_data;
        @(negedge clk);
        check("start_width", bus.gcd_start, 0);
        check("data_hold_b", bus.gcd_data, eb);
        if (eng_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          p = eng_q.pop_front();
          check("engine_a", ea, p.a);
          check("engine_b", eb, p.b);
        end
        t = 0;
        while (eng_stall && t < 3000) begin @(negedge clk); t++; end
        repeat (eng_delay) @(negedge clk);
        if (!hang_now) begin
          bus.gcd_done = 1'b1; bus.gcd_result = gcd_f(ea, eb);
          @(negedge clk);
          bus.gcd_done = 1'b0; bus.gcd_result = 16'($urandom);
          if (ep == rst_epoch) check("done_to_valid", bus.out_valid, 1);
          else                 check("stale_done_ignored", bus.out_valid, 0);
        end
      end
    end
  end

  // Output checker: every handshake against the scoreboard, stability while stalled.
  initial begin : out_check
    bit          hold;
    logic [15:0] hd;
    logic        hz, he;
    res_t        e;
    hold = 1'b0; hd = '0; hz = 1'b0; he = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", bus.out_data, hd);
          check("hold_zero", bus.out_zero, hz);
          check("hold_err", bus.out_err, he);
        end
        if (bus.out_valid) begin
          check("no_start_in_resp", bus.gcd_start, 0);
          if (bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
              e = exp_q.pop_front();
              check("out_data", bus.out_data, e.data);
              check("out_zero", bus.out_zero, e.zero);
              check("out_err", bus.out_err, e.err);
            end
          end
          hold = !bus.out_ready;
          hd = bus.out_data; hz = bus.out_zero; he = bus.out_err;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    logic [15:0] d;
    logic        z, e;
    int          n;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_gcd_start", bus.gcd_start, 0);
    check("rst_gcd_data", bus.gcd_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_zero", bus.out_zero, 0);
    check("rst_out_err", bus.out_err, 0);
    tick(); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);
    tick();

    // (143,78) -> 13, start one cycle after the pop
    push(16'd143, 16'd78, 1'b0);
    @(negedge clk); check("start_not_yet", bus.gcd_start, 0);
    @(negedge clk); check("start_pop_plus1", bus.gcd_start, 1);
    wait_out(d, z, e);
    check("lit_143_78", d, 13); check("lit_143_78_zero", z, 0);
    tick();

    // zero short-circuit: result one cycle after the pop, engine untouched
    push(16'd0, 16'd25, 1'b0);
    @(negedge clk); check("zero_not_yet", bus.out_valid, 0);
    @(negedge clk); check("zero_pop_plus1", bus.out_valid, 1);
    check("lit_0_25", bus.out_data, 25); check("lit_0_25_zero", bus.out_zero, 1);
    tick();
    push(16'd0, 16'd0, 1'b0);
    wait_out(d, z, e);
    check("lit_0_0", d, 0); check("lit_0_0_zero", z, 1);
    tick();

    // consumer stalls for 10 cycles on result 7 with another pair waiting
    bus.out_ready = 1'b0;
    push(16'd21, 16'd14, 1'b0);
    wait_out(d, z, e);
    check("lit_21_14", d, 7);
    tick();
    push(16'd9, 16'd6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("resp_hold_valid", bus.out_valid, 1);
      check("resp_hold_data", bus.out_data, 7);
    end
    tick(); bus.out_ready = 1'b1;
    tick();
    wait_out(d, z, e);
    check("lit_9_6", d, 3);
    tick();

    // engine stalled: four queued pairs fill the FIFO, the fifth waits for a pop
    eng_stall = 1'b1;
    push(16'd100, 16'd75, 1'b0);
    repeat (6) tick();
    push(16'd12, 16'd8, 1'b0);
    push(16'd35, 16'd14, 1'b0);
    push(16'd0, 16'd9, 1'b0);
    push(16'd81, 16'd27, 1'b0);
    @(negedge clk); check("full_in_ready", bus.in_ready, 0);
    tick();
    fork
      push(16'd17, 16'd5, 1'b0);
      begin
        repeat (5) tick();
        check("full_in_ready_held", bus.in_ready, 0);
        eng_stall = 1'b0;
      end
    join
    drain();

    // reset while the engine is busy and two pairs are queued
    eng_stall = 1'b1;
    push(16'd60, 16'd48, 1'b0);
    push(16'd7, 16'd3, 1'b0);
    push(16'd8, 16'd4, 1'b0);
    repeat (6) tick();
    rst = 1'b1; exp_q.delete(); eng_q.delete(); rst_epoch++;
    tick(); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_start", bus.gcd_start, 0);
    tick();
    eng_stall = 1'b0;
    repeat (20) tick();
    @(negedge clk); check("no_stale_result", bus.out_valid, 0);
    tick();

`ifdef GCD_TIMEOUT_EN
    // engine never answers: error result after TMO WAIT cycles, then recovery
    eng_hang = 1'b1;
    push(16'd5, 16'd3, 1'b1);
    n = 0;
    while (!bus.gcd_start && n < 50) begin @(negedge clk); n++; end
    check("tmo_start_seen", bus.gcd_start, 1);
    @(negedge clk);
    n = 0;
    do begin @(negedge clk); if (!bus.out_valid) n++; end while (!bus.out_valid && n < 200);
    check("tmo_wait_cycles", n, TMO);
    check("tmo_err", bus.out_err, 1); check("tmo_data", bus.out_data, 0);
    check("tmo_zero", bus.out_zero, 0);
    tick();
    eng_hang = 1'b0;
    push(16'd48, 16'd18, 1'b0);
    wait_out(d, z, e);
    check("lit_48_18", d, 6); check("lit_48_18_err", e, 0);
    tick();
`endif

    drain();
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
